// File: rtl/cart_boot_handshake.sv
// ---------------------------------------------------------------------------
// cart_boot_handshake
//   Runs the cartridge mapper boot handshake. The mapper is held in reset for
//   two cycles and then receives an unlock address pair. After that it
//   streams a framed payload word back on its SO pin. The block captures the
//   frame, checks it against the GOLD word, and retries on failure until the
//   retry budget is used up.
//
// Ports
//   clk_i    : single clock, rising edge
//   rst_i    : synchronous active-high reset
//   start_i  : one-cycle run request, accepted only in IDLE
//   si_i     : serial stream from the mapper
//   addr_o   : unlock address byte to the mapper (8'hFF when idle)
//   mrstn_o  : active-low mapper reset
//   busy_o   : handshake in progress
//   done_o   : handshake finished, held until the next accepted start
//   pass_o   : result qualifier for done_o
//   word_o   : payload bits 16:1 of the last captured frame
//   tries_o  : failed attempts in the current run (saturating)
//
// state | meaning
// IDLE  | waiting for start_i
// MRST  | mapper reset low for two cycles
// ACK   | drive unlock byte 8'h5A
// NAK   | drive unlock byte 8'hA5
// HUNT  | wait for the start bit, bounded by HUNT_MAX
// CAPT  | shift in frame bits 1..17
// STOP  | sample the two trailer bits
// CHECK | validate the frame and latch the payload
// FIN   | result presented for one cycle before IDLE
// ---------------------------------------------------------------------------
module cart_boot_handshake #(
   parameter logic [15:0] GOLD     = 16'h28A0,
   parameter int          HUNT_MAX = 4,
   parameter int          RETRIES  = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        si_i,
   output logic [7:0]  addr_o,
   output logic        mrstn_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic [15:0] word_o,
   output logic [1:0]  tries_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_MRST, S_ACK, S_NAK, S_HUNT, S_CAPT, S_STOP, S_CHECK, S_FIN
   } state_t;

   localparam logic [3:0] HUNT_LAST = 4'(HUNT_MAX - 1);
   localparam logic [1:0] RETRY_MAX = 2'(RETRIES);

   state_t      state_q, state_d;
   logic        phase_q, phase_d;    // second-cycle flag for MRST and STOP
   logic [3:0]  hunt_q,  hunt_d;
   logic [4:0]  bit_q,   bit_d;
   logic [17:0] frame_q, frame_d;
   logic [1:0]  trail_q, trail_d;
   logic        done_q,  done_d;
   logic        pass_q,  pass_d;
   logic [15:0] word_q,  word_d;
   logic [1:0]  tries_q, tries_d;

   logic        attempt_fail;
   logic        frame_ok;

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         phase_q <= 1'b0;
         hunt_q  <= '0;
         bit_q   <= '0;
         frame_q <= '0;
         trail_q <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         word_q  <= '0;
         tries_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         hunt_q  <= hunt_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         trail_q <= trail_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         word_q  <= word_d;
         tries_q <= tries_d;
      end
   end

   assign frame_ok = (frame_q[0] == 1'b0) && (frame_q[17] == 1'b0) &&
                     (frame_q[16:1] == GOLD) && (&trail_q);

   // next-state and datapath
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      hunt_d       = hunt_q;
      bit_d        = bit_q;
      frame_d      = frame_q;
      trail_d      = trail_q;
      done_d       = done_q;
      pass_d       = pass_q;
      word_d       = word_q;
      tries_d      = tries_q;
      attempt_fail = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_MRST;
               phase_d = 1'b0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               tries_d = '0;
            end
         end
         S_MRST: begin
            if (phase_q) begin
               state_d = S_ACK;
               phase_d = 1'b0;
            end else begin
               phase_d = 1'b1;
            end
         end
         S_ACK: state_d = S_NAK;
         S_NAK: begin
            state_d = S_HUNT;
            hunt_d  = '0;
         end
         S_HUNT: begin
            if (!si_i) begin
               frame_d[0] = 1'b0;
               bit_d      = 5'd1;
               state_d    = S_CAPT;
            end else if (hunt_q == HUNT_LAST) begin
               attempt_fail = 1'b1;
            end else begin
               hunt_d = hunt_q + 4'd1;
            end
         end
         S_CAPT: begin
            frame_d[bit_q] = si_i;
            bit_d          = bit_q + 5'd1;
            if (bit_q == 5'd17) begin
               state_d = S_STOP;
               phase_d = 1'b0;
            end
         end
         S_STOP: begin
            trail_d[phase_q] = si_i;
            if (phase_q) begin
               state_d = S_CHECK;
               phase_d = 1'b0;
            end else begin
               phase_d = 1'b1;
            end
         end
         S_CHECK: begin
            word_d = frame_q[16:1];
            if (frame_ok) begin
               state_d = S_FIN;
               done_d  = 1'b1;
               pass_d  = 1'b1;
            end else begin
               attempt_fail = 1'b1;
            end
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Shared failure path for HUNT timeout and a rejected frame.
      if (attempt_fail) begin
         if (tries_q < RETRY_MAX) begin
            tries_d = tries_q + 2'd1;
            state_d = S_MRST;
            phase_d = 1'b0;
         end else begin
            state_d = S_FIN;
            done_d  = 1'b1;
            pass_d  = 1'b0;
         end
      end
   end

   // outputs
   always_comb begin
      addr_o  = 8'hFF;
      mrstn_o = 1'b1;
      busy_o  = 1'b1;
      unique case (state_q)
         S_IDLE:  busy_o  = 1'b0;
         S_FIN:   busy_o  = 1'b0;
         S_MRST:  mrstn_o = 1'b0;
         S_ACK:   addr_o  = 8'h5A;
         S_NAK:   addr_o  = 8'hA5;
         default: ;
      endcase
   end

   assign done_o  = done_q;
   assign pass_o  = pass_q;
   assign word_o  = word_q;
   assign tries_o = tries_q;

endmodule

// File: tb/tb_cart_boot_handshake.sv
module tb_cart_boot_handshake;

   localparam logic [15:0] GOLD     = 16'h28A0;
   localparam int          HUNT_MAX = 4;
   localparam int          RETRIES  = 3;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        si_i;
   logic [7:0]  addr_o;
   logic        mrstn_o;
   logic        busy_o;
   logic        done_o;
   logic        pass_o;
   logic [15:0] word_o;
   logic [1:0]  tries_o;

   cart_boot_handshake #(.GOLD(GOLD), .HUNT_MAX(HUNT_MAX), .RETRIES(RETRIES)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .si_i(si_i),
      .addr_o(addr_o), .mrstn_o(mrstn_o), .busy_o(busy_o), .done_o(done_o),
      .pass_o(pass_o), .word_o(word_o), .tries_o(tries_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-attempt behaviour of the mapper model for the current run.
   int          att_delay   [4];
   logic [15:0] att_payload [4];
   logic        att_stop    [4];
   logic        att_t0      [4];
   logic        att_t1      [4];
   logic        att_stuck   [4];
   int          att_i;

   task automatic set_att(input int i, input int d, input logic [15:0] p,
                          input logic sb, input logic t0, input logic t1, input logic st);
      att_delay[i] = d; att_payload[i] = p; att_stop[i] = sb;
      att_t0[i] = t0; att_t1[i] = t1; att_stuck[i] = st;
   endtask

   task automatic set_all_good();
      for (int i = 0; i < 4; i++) set_att(i, 0, GOLD, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   // Stream position j: 0 start bit, 1..16 payload LSB first, 17 stop, 18/19 trailer.
   function automatic logic stream_bit(input int a, input int j);
      if (att_stuck[a] || j < 0) return 1'b1;
      if (j == 0)  return 1'b0;
      if (j <= 16) return att_payload[a][j-1];
      if (j == 17) return att_stop[a];
      if (j == 18) return att_t0[a];
      if (j == 19) return att_t1[a];
      return 1'b1;
   endfunction

   // Mapper: restarts its stream position when it sees the second unlock byte.
   initial begin
      int k;
      int cur;
      si_i = 1'b1;
      k    = 1000;
      cur  = 0;
      forever begin
         @(posedge clk_i); #1;
         if (addr_o == 8'hA5) begin
            cur = (att_i > 3) ? 3 : att_i;
            att_i++;
            k    = -1;
            si_i = 1'b1;
         end else begin
            if (k < 1000) k++;
            si_i = stream_bit(cur, k - att_delay[cur]);
         end
      end
   end

   // Reference model: outcome of a run from the per-attempt behaviour.
   typedef struct {
      logic        p;
      int          t;
      logic [15:0] w;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] word_m = 16'h0000;

   function automatic exp_t model_run();
      exp_t e;
      int   fails;
      fails = 0;
      e.p   = 1'b0;
      e.lat = 0;
      for (int i = 0; i <= RETRIES; i++) begin
         if (att_stuck[i] || att_delay[i] >= HUNT_MAX) begin
            e.lat += 4 + HUNT_MAX;            // reset, unlock pair, full hunt
         end else begin
            e.lat += 4 + (att_delay[i] + 1) + 17 + 2 + 1;
            word_m = att_payload[i];
            if (att_payload[i] == GOLD && att_stop[i] == 1'b0 && att_t0[i] && att_t1[i]) begin
               e.p = 1'b1;
               break;
            end
         end
         fails++;
      end
      e.t = (fails > RETRIES) ? RETRIES : fails;
      e.w = word_m;
      return e;
   endfunction

   // Monitor: counts busy cycles and checks each completed run.
   initial begin
      logic done_prev;
      logic busy_prev;
      int   lat;
      exp_t e;
      done_prev = 1'b0;
      busy_prev = 1'b0;
      lat       = 0;
      forever begin
         @(posedge clk_i); #1;
         if (busy_o && !busy_prev) lat = 0;
         if (busy_o) lat++;
         if (done_o && !done_prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("pass",    32'(pass_o),  32'(e.p));
               chk("tries",   32'(tries_o), 32'(e.t));
               chk("word",    32'(word_o),  32'(e.w));
               chk("latency", 32'(lat),     32'(e.lat));
            end
         end
         done_prev = done_o;
         busy_prev = busy_o;
      end
   end

   task automatic pulse_start();
      start_i = 1'b1;
      @(posedge clk_i); #2;
      start_i = 1'b0;
   endtask

   task automatic run_case();
      @(posedge clk_i); #2;
      att_i = 0;
      exp_q.push_back(model_run());
      pulse_start();
   endtask

   task automatic wait_done(input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk_i); #2;
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk({name, "_timeout"}, 32'd0, 32'd1);
         exp_q.delete();
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_addr"},  32'(addr_o),  32'hFF);
      chk({tag, "_mrstn"}, 32'(mrstn_o), 32'd1);
      chk({tag, "_busy"},  32'(busy_o),  32'd0);
      chk({tag, "_done"},  32'(done_o),  32'd0);
      chk({tag, "_pass"},  32'(pass_o),  32'd0);
      chk({tag, "_word"},  32'(word_o),  32'd0);
      chk({tag, "_tries"}, 32'(tries_o), 32'd0);
   endtask

   initial begin
      int r;
      rst_i   = 1'b1;
      start_i = 1'b0;
      att_i   = 0;
      set_all_good();
      repeat (3) @(posedge clk_i);
      #2;
      check_reset("reset");
      rst_i = 1'b0;

      // Conforming mapper.
      set_all_good();
      run_case();
      wait_done("conform");
      // A start during the FIN cycle must not launch a run.
      pulse_start();
      @(posedge clk_i); #2;
      chk("fin_start_busy", 32'(busy_o), 32'd0);
      chk("fin_start_done", 32'(done_o), 32'd1);

      // SI stuck high on every attempt.
      for (int i = 0; i < 4; i++) set_att(i, 0, GOLD, 1'b0, 1'b1, 1'b1, 1'b1);
      run_case();
      wait_done("stuck");

      // Wrong payload once, then conforming.
      set_all_good();
      set_att(0, 0, 16'h28A1, 1'b0, 1'b1, 1'b1, 1'b0);
      run_case();
      wait_done("bad_payload");

      // Stop bit 1 once.
      set_all_good();
      set_att(0, 0, GOLD, 1'b1, 1'b1, 1'b1, 1'b0);
      run_case();
      wait_done("bad_stop");

      // Trailer sample 0 once (second sample), then first sample 0.
      set_all_good();
      set_att(0, 0, GOLD, 1'b0, 1'b1, 1'b0, 1'b0);
      set_att(1, 0, GOLD, 1'b0, 1'b0, 1'b1, 1'b0);
      run_case();
      wait_done("bad_trailer");

      // Start bit late by HUNT_MAX-1 (ok) and by HUNT_MAX (timeout).
      for (int i = 0; i < 4; i++) set_att(i, HUNT_MAX - 1, GOLD, 1'b0, 1'b1, 1'b1, 1'b0);
      run_case();
      wait_done("delay_ok");
      set_all_good();
      set_att(0, HUNT_MAX, GOLD, 1'b0, 1'b1, 1'b1, 1'b0);
      run_case();
      wait_done("delay_late");

      // Start during busy must not disturb a run.
      set_all_good();
      set_att(0, 1, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0);
      run_case();
      repeat (8) @(posedge clk_i);
      #2;
      pulse_start();
      wait_done("start_in_busy");

      // Reset in the middle of capture.
      @(posedge clk_i); #2;
      set_all_good();
      att_i = 0;
      pulse_start();
      repeat (10) @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      @(posedge clk_i); #2;
      rst_i  = 1'b0;
      word_m = 16'h0000;
      check_reset("midrst");

      // Randomized attempt mixes.
      for (int run = 0; run < 10; run++) begin
         for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 9);
            set_att(i, $urandom_range(0, HUNT_MAX - 1), GOLD, 1'b0, 1'b1, 1'b1, 1'b0);
            case (r)
               5: att_delay[i]   = $urandom_range(HUNT_MAX, HUNT_MAX + 2);
               6: att_payload[i] = GOLD ^ (16'h0001 << $urandom_range(0, 15));
               7: att_stop[i]    = 1'b1;
               8: if ($urandom_range(0, 1) == 0) att_t0[i] = 1'b0; else att_t1[i] = 1'b0;
               9: att_stuck[i]   = 1'b1;
               default: ;
            endcase
         end
         run_case();
         wait_done("random");
      end

      repeat (5) @(posedge clk_i);
      #2;
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cart_boot_handshake.md
CART_BOOT_HANDSHAKE -- requirements
Module: cart_boot_handshake

Interface
REQ-001 Parameter: GOLD, 16'h28A0, expected payload word of the mapper boot bit-stream.
REQ-002 Parameter: HUNT_MAX, 4, cycles allowed after unlock to see the start bit (range 1..15).
REQ-003 Parameter: RETRIES, 3, extra attempts after the first failed attempt (range 0..3).
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 START  input  1  one-cycle request to run the boot handshake; ignored while BUSY=1.
REQ-007 SI  input  1  serial bit-stream from the mapper SO pin, sampled on rising CLK.
REQ-008 ADDR  output  8  address byte driven to the mapper unlock decoder.
REQ-009 MRSTn  output  1  active-low reset pulse driven to the mapper.
REQ-010 BUSY  output  1  handshake in progress.
REQ-011 DONE  output  1  handshake finished; held until the next accepted START or RST.
REQ-012 PASS  output  1  valid only with DONE=1; 1 means the stream matched.
REQ-013 WORD  output  16  payload bits 16:1 of the last captured frame.
REQ-014 TRIES  output  2  number of failed attempts in the current run.

Function
REQ-015 States: IDLE, MRST, ACK, NAK, HUNT, CAPT, STOP, CHECK, FIN; idle ADDR value shall be 8'hFF in every state except ACK and NAK.
REQ-016 IDLE: BUSY=0; an accepted START clears DONE, PASS and TRIES, sets BUSY=1, and moves to MRST on the next edge.
REQ-017 MRST: MRSTn=0 for exactly 2 cycles, then ACK; SI is ignored in MRST.
REQ-018 ACK: ADDR=8'h5A for exactly 1 cycle, then NAK.
REQ-019 NAK: ADDR=8'hA5 for exactly 1 cycle, then HUNT with the hunt counter at 0.
REQ-020 HUNT: each cycle, SI=0 stores frame bit 0 = 0, sets the bit counter to 1, and moves to CAPT; SI=1 increments the hunt counter, and reaching HUNT_MAX is an attempt failure.
REQ-021 CAPT: each cycle stores SI into frame bit[counter] and increments the counter; after frame bit 17 is stored, go to STOP.
REQ-022 STOP: sample SI for 2 cycles; both samples shall be 1 for the trailer to be valid.
REQ-023 CHECK (1 cycle): the frame is valid when bit 0=0, bit 17=0, bits 16:1=GOLD and the trailer is valid; WORD is loaded with frame bits 16:1 whether the frame is valid or not.
REQ-024 On a valid frame: go to FIN with PASS=1.
REQ-025 On an attempt failure (HUNT timeout or invalid frame) with TRIES<RETRIES: increment TRIES and return to MRST.
REQ-026 On an attempt failure with TRIES=RETRIES: go to FIN with PASS=0; TRIES saturates and never wraps.
REQ-027 FIN: DONE=1 and BUSY=0; return to IDLE on the next edge; DONE, PASS, WORD and TRIES hold until an accepted START.
REQ-028 Expected mapper stream on SI, first bit first: one start bit 0, GOLD LSB-first, one stop bit 0, then constant 1.
REQ-029 The first HUNT cycle is the cycle directly after NAK; with a conforming mapper, the start bit is seen in that cycle.
REQ-030 A START that arrives in the same cycle as the FIN-to-IDLE transition is not accepted.

Reset
REQ-031 RST=1 takes precedence over all other inputs on any edge, including mid-run.
REQ-032 Reset state: state=IDLE, ADDR=8'hFF, MRSTn=1, BUSY=0, DONE=0, PASS=0, WORD=16'h0000, TRIES=0, frame and counters cleared.

Verification
REQ-033 Conforming mapper model, START pulse -> MRSTn low 2 cycles, ADDR 5A then A5, start bit seen in the first HUNT cycle, DONE=1, PASS=1, WORD=16'h28A0, TRIES=0, 25 cycles from START to DONE.
REQ-034 SI stuck at 1 with RETRIES=3, HUNT_MAX=4 -> four attempts each end in HUNT timeout, DONE=1, PASS=0, TRIES=3.
REQ-035 Payload 16'h28A1 on the first attempt, conforming model afterwards -> TRIES=1, PASS=1, WORD=16'h28A0.
REQ-036 Correct payload with stop bit 1, or with a trailer sample of 0 -> attempt fails and TRIES increments.
REQ-037 Start bit delayed 3 cycles after NAK with HUNT_MAX=4 -> PASS=1; delayed 4 cycles -> attempt fails.
REQ-038 RST asserted during CAPT, and a START pulse during BUSY -> after RST, all outputs equal their reset values; the START pulse during BUSY has no effect on state or TRIES.
